// File: rtl/spi_pkg.sv
// Shared SPI definitions: sequencer state encoding, default widths and the
// CPOL/CPHA mode encoding used by the controller and the clock generator.
package spi_pkg;

    localparam int SPI_DIV_WIDTH = 8;
    localparam int SPI_CNT_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } sclk_state_e;

    // Mode number is {cpol, cpha}, matching the usual SPI mode 0..3 naming.
    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_e;

    function automatic spi_mode_e spi_mode(input logic cpol, input logic cpha);
        return spi_mode_e'({cpol, cpha});
    endfunction

endpackage

// File: rtl/spi_half_period_counter.sv
// Free-running 0..i_term counter with a terminal-count pulse; i_load clears it.
// Also used by the controller as its CS setup timer.
module spi_half_period_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == i_term);

    // Count while enabled, wrapping to zero on terminal count; load wins.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_load)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_tc ? '0 : r_cnt + W'(1);
    end

endmodule

// File: rtl/spi_sclk_generator.sv
// SPI master SCLK generator: produces SCLK for an N-bit transfer plus
// system-clock-synchronous sample/shift strobes according to CPOL/CPHA.
module spi_sclk_generator
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH = SPI_DIV_WIDTH,
    parameter int CNT_WIDTH = SPI_CNT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_cpol,
    input  logic                 i_cpha,
    input  logic [DIV_WIDTH-1:0] i_half_period,
    input  logic [CNT_WIDTH-1:0] i_num_bits,
    output logic                 o_sclk,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic                 o_rise,
    output logic                 o_fall,
    output logic                 o_sample,
    output logic                 o_shift,
    output logic                 o_done
);

    sclk_state_e          r_state, w_next;
    spi_mode_e            r_mode;
    logic [DIV_WIDTH-1:0] r_hm1;
    logic [CNT_WIDTH-1:0] r_n;
    logic [CNT_WIDTH:0]   r_edge_cnt;
    logic [CNT_WIDTH:0]   w_k;
    logic                 w_tc, w_load, w_en, w_last, w_cpol, w_cpha;
    logic                 w_rise, w_fall, w_sample, w_shift, w_done;

    assign w_cpol  = r_mode[1];
    assign w_cpha  = r_mode[0];
    assign w_k     = r_edge_cnt + (CNT_WIDTH+1)'(1);
    assign w_last  = (w_k == {r_n, 1'b0});
    assign o_ready = (r_state == ST_IDLE);
    assign o_busy  = !o_ready;

    spi_half_period_counter #(.W(DIV_WIDTH)) u_hp_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_en   (w_en),
        .i_term (r_hm1),
        .o_tc   (w_tc)
    );

    // Next state and next-cycle strobes; abort beats a coincident terminal count.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_en     = 1'b0;
        w_rise   = 1'b0;
        w_fall   = 1'b0;
        w_sample = 1'b0;
        w_shift  = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    w_next = (i_num_bits == '0) ? ST_HOLD : ST_RUN;
                end
            end
            ST_RUN: begin
                w_en = 1'b1;
                if (i_abort) begin
                    w_load = 1'b1;
                    w_next = ST_IDLE;
                end else if (w_tc) begin
                    // Toggle k: odd k is the leading edge, even k trailing.
                    w_rise = !o_sclk;
                    w_fall = o_sclk;
                    if (w_cpha) begin
                        w_shift  = w_k[0];
                        w_sample = !w_k[0];
                    end else begin
                        w_sample = w_k[0];
                        w_shift  = !w_k[0] && !w_last;
                    end
                    if (w_last)
                        w_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_en = 1'b1;
                if (i_abort) begin
                    w_load = 1'b1;
                    w_next = ST_IDLE;
                end else if (w_tc) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, shadow registers, SCLK, edge counter and registered strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_mode     <= SPI_MODE0;
            r_hm1      <= '0;
            r_n        <= '0;
            r_edge_cnt <= '0;
            o_sclk     <= 1'b0;
            o_rise     <= 1'b0;
            o_fall     <= 1'b0;
            o_sample   <= 1'b0;
            o_shift    <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            r_state  <= w_next;
            o_rise   <= w_rise;
            o_fall   <= w_fall;
            o_sample <= w_sample;
            o_shift  <= w_shift;
            o_done   <= w_done;
            case (r_state)
                ST_IDLE: begin
                    o_sclk     <= i_cpol;
                    r_edge_cnt <= '0;
                    if (i_start) begin
                        r_mode <= spi_mode(i_cpol, i_cpha);
                        r_hm1  <= (i_half_period == '0) ? '0
                                                        : i_half_period - DIV_WIDTH'(1);
                        r_n    <= i_num_bits;
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        o_sclk     <= w_cpol;
                        r_edge_cnt <= '0;
                    end else if (w_tc) begin
                        o_sclk     <= !o_sclk;
                        r_edge_cnt <= w_k;
                    end
                end
                default: begin
                    if (i_abort)
                        o_sclk <= w_cpol;
                    r_edge_cnt <= '0;
                end
            endcase
        end
    end

endmodule
